// File: rtl/aes_pkg.sv
// Shared AES datapath constants, SubBytes FSM state encoding and byte-slice helper.
// Byte 0 of a block sits in the most significant byte, matching FIPS-197 column order.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = AES_BLOCK_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_BUSY,
        SB_DONE
    } sb_state_e;

    // Most significant bit position of byte idx within a block.
    function automatic int byte_msb(input int idx);
        return AES_BLOCK_W - 1 - AES_BYTE_W * idx;
    endfunction

endpackage

// File: rtl/sbox.sv
// FIPS-197 forward S-box: purely combinational 256-entry byte lookup.
module sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] in_i,
    output logic [AES_BYTE_W-1:0] out_o
);

    localparam logic [0:255][AES_BYTE_W-1:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TABLE[in_i];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: substitutes NSBOX bytes per cycle from the top of a rotating
// state register, so after 16/NSBOX cycles every byte is substituted and back in place.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int NSBOX = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] state_out,
    output logic                   busy
);

    localparam int ITER    = AES_NBYTES / NSBOX;
    localparam int SLICE_W = AES_BYTE_W * NSBOX;
    localparam int CNT_W   = (ITER > 1) ? $clog2(ITER) : 1;

    if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4 && NSBOX != 8 && NSBOX != 16) begin : g_bad_nsbox
        $error("sub_bytes_iter: NSBOX must be 1, 2, 4, 8 or 16");
    end

    sb_state_e              fsm_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [AES_BLOCK_W-1:0] state_q;
    logic [AES_BLOCK_W-1:0] state_d;
    logic [SLICE_W-1:0]     sub_w;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   busy_q;

    for (genvar i = 0; i < NSBOX; i++) begin : g_sbox
        sbox u_sbox (
            .in_i  (state_q[byte_msb(i) -: AES_BYTE_W]),
            .out_o (sub_w[SLICE_W-1-AES_BYTE_W*i -: AES_BYTE_W])
        );
    end

    // Substituted top slice wraps around to the bottom of the register.
    if (NSBOX == AES_NBYTES) begin : g_rot_full
        assign state_d = sub_w;
    end else begin : g_rot_part
        assign state_d = {state_q[AES_BLOCK_W-SLICE_W-1:0], sub_w};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= SB_IDLE;
            cnt_q       <= '0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            fsm_q       <= SB_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                SB_IDLE: begin
                    if (in_valid) begin
                        state_q    <= state_in;
                        cnt_q      <= '0;
                        fsm_q      <= SB_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SB_BUSY: begin
                    state_q <= state_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        fsm_q       <= SB_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                SB_DONE: begin
                    if (out_ready) begin
                        fsm_q       <= SB_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= SB_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed and random checks of sub_bytes_iter against an S-box model computed
// from GF(2^8) inversion plus the FIPS-197 affine map.
module tb_sub_bytes_iter;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         clear     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] state_in  = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] state_out;

    logic         sw_clear     = 1'b0;
    logic         sw_in_valid  = 1'b0;
    logic         sw_out_ready = 1'b0;
    logic [127:0] sw_state_in  = '0;
    logic         sw_in_ready  [5];
    logic         sw_out_valid [5];
    logic         sw_busy      [5];
    logic [127:0] sw_state_out [5];

    int vectors = 0;
    int errors  = 0;
    logic [7:0] sb_model [256];

    always #5 clk = ~clk;

    sub_bytes_iter #(.NSBOX(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    // One instance per legal NSBOX, all fed the same block in parallel.
    for (genvar g = 0; g < 5; g++) begin : g_sweep
        sub_bytes_iter #(.NSBOX(1 << g)) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (sw_clear),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_in_ready[g]),
            .state_in  (sw_state_in),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready),
            .state_out (sw_state_out[g]),
            .busy      (sw_busy[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic initModel();
        logic [7:0] r;
        for (int x = 0; x < 256; x++) begin
            r = 8'h00;
            if (x != 0) begin
                r = 8'h01;
                for (int k = 0; k < 254; k++) r = gmul(r, 8'(x));
            end
            sb_model[x] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                          ^ {r[3:0], r[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] subModel(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb_model[s[127-8*i -: 8]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes one block through the main DUT; lat counts edges from accept to out_valid.
    task automatic applyStimulus(input logic [127:0] data, output int lat, output logic [127:0] result);
        int w = 0;
        state_in = data;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        result = state_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (state_out !== 128'h0) begin errors++; $display("[TB] FAIL reset_state_out: got %h expected 0", state_out); end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        vectors++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %b expected 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] res;
        applyStimulus(128'h193de3bea0f4e22b9ac68d2ae9f84808, lat, res);
        vectors++;
        if (lat !== 16) begin errors++; $display("[TB] FAIL fips_latency: got %0d expected 16", lat); end
        vectors++;
        if (res !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
            errors++;
            $display("[TB] FAIL fips_result: got %h expected d42711aee0bf98f1b8b45de51e415230", res);
        end
    endtask

    task automatic test_sweep();
        logic [127:0] pats [2];
        logic [127:0] exps [2];
        int           lat  [5];
        logic [127:0] res  [5];
        pats[0] = '0;
        pats[1] = '1;
        exps[0] = {16{8'h63}};
        exps[1] = {16{8'h16}};
        for (int p = 0; p < 2; p++) begin
            foreach (lat[g]) begin lat[g] = 0; res[g] = '0; end
            sw_state_in = pats[p];
            sw_in_valid = 1'b1;
            tick();
            sw_in_valid = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                tick();
                for (int g = 0; g < 5; g++)
                    if (sw_out_valid[g] && lat[g] == 0) begin lat[g] = c; res[g] = sw_state_out[g]; end
            end
            for (int g = 0; g < 5; g++) begin
                vectors++;
                if (lat[g] !== (16 >> g)) begin
                    errors++;
                    $display("[TB] FAIL sweep_latency nsbox=%0d pat=%0d: got %0d expected %0d", 1 << g, p, lat[g], 16 >> g);
                end
                vectors++;
                if (res[g] !== exps[p]) begin
                    errors++;
                    $display("[TB] FAIL sweep_result nsbox=%0d: got %h expected %h", 1 << g, res[g], exps[p]);
                end
            end
            sw_out_ready = 1'b1;
            tick();
            sw_out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int w = 0;
        logic [127:0] exp = 128'h637c777bf26b6fc53001672bfed7ab76;
        state_in = 128'h000102030405060708090a0b0c0d0e0f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && w < 50) begin tick(); w++; end
        vectors++;
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_done_timeout: got out_valid %b expected 1", out_valid); end
        for (int cyc = 0; cyc < 10; cyc++) begin
            vectors++;
            if ({out_valid, in_ready, state_out} !== {1'b1, 1'b0, exp}) begin
                errors++;
                $display("[TB] FAIL bp_hold cyc=%0d: got v=%b r=%b %h expected v=1 r=0 %h",
                         cyc, out_valid, in_ready, state_out, exp);
            end
            if (cyc == 3) begin
                in_valid = 1'b1;
                state_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
            end
            if (cyc == 4) in_valid = 1'b0;
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL bp_release: got %b expected 010", {out_valid, in_ready, busy});
        end
        tick();
        vectors++;
        if ({busy, in_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_no_capture: got %b expected 01", {busy, in_ready});
        end
    endtask

    task automatic test_clear();
        int lat;
        logic seen = 1'b0;
        logic [127:0] res;
        state_in = 128'h00112233445566778899aabbccddeeff;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL clear_idle: got %b expected 100", {in_ready, busy, out_valid});
        end
        repeat (20) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin errors++; $display("[TB] FAIL clear_no_output: got out_valid seen %b expected 0", seen); end
        applyStimulus(128'h000102030405060708090a0b0c0d0e0f, lat, res);
        vectors++;
        if (lat !== 16) begin errors++; $display("[TB] FAIL clear_next_latency: got %0d expected 16", lat); end
        vectors++;
        if (res !== 128'h637c777bf26b6fc53001672bfed7ab76) begin
            errors++;
            $display("[TB] FAIL clear_next_result: got %h expected 637c777bf26b6fc53001672bfed7ab76", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] data [4];
        int idx = 0, rcv = 0, last_acc = -1;
        logic pre_ready, pre_valid;
        logic [127:0] pre_out;
        data[0] = 128'h0123456789abcdeffedcba9876543210;
        data[1] = 128'h3243f6a8885a308d313198a2e0370734;
        data[2] = 128'hffeeddccbbaa99887766554433221100;
        data[3] = 128'h5a5a5a5aa5a5a5a5c3c3c3c33c3c3c3c;
        state_in = 128'h1111111122222222333333334444444;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, busy, state_out} !== {3'b100, 128'h0}) begin
            errors++;
            $display("[TB] FAIL async_reset: got r=%b v=%b b=%b %h expected r=1 v=0 b=0 0",
                     in_ready, out_valid, busy, state_out);
        end
        tick();
        #2 rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        state_in  = data[0];
        for (int c = 0; c < 200 && rcv < 4; c++) begin
            pre_ready = in_ready;
            pre_valid = out_valid;
            pre_out   = state_out;
            tick();
            if (pre_ready && in_valid) begin
                // Each block occupies one IDLE cycle, 16 BUSY cycles and one DONE cycle.
                if (last_acc >= 0) begin
                    vectors++;
                    if (c - last_acc !== 18) begin
                        errors++;
                        $display("[TB] FAIL b2b_spacing: got %0d expected 18", c - last_acc);
                    end
                end
                last_acc = c;
                idx++;
                if (idx < 4) state_in = data[idx];
                else in_valid = 1'b0;
            end
            if (pre_valid) begin
                vectors++;
                if (pre_out !== subModel(data[rcv])) begin
                    errors++;
                    $display("[TB] FAIL b2b_result %0d: got %h expected %h", rcv, pre_out, subModel(data[rcv]));
                end
                rcv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (rcv !== 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 4", rcv); end
        tick();
    endtask

    task automatic test_random();
        logic [127:0] q [$];
        logic [127:0] cur = '0;
        logic [127:0] exp;
        logic [127:0] pre_out;
        logic pre_acc, pre_hs;
        int sent = 0, rcv = 0, cyc = 0;
        while (rcv < 1000 && cyc < 60000) begin
            if (!in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
                cur = {$urandom, $urandom, $urandom, $urandom};
                state_in = cur;
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            pre_acc = in_valid && in_ready;
            pre_hs  = out_valid && out_ready;
            pre_out = state_out;
            tick();
            cyc++;
            if (pre_acc) begin
                q.push_back(subModel(cur));
                sent++;
                in_valid = 1'b0;
            end
            if (pre_hs) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra_output: got %h expected no block", pre_out);
                end else begin
                    exp = q.pop_front();
                    if (pre_out !== exp) begin
                        errors++;
                        $display("[TB] FAIL rand_result %0d: got %h expected %h", rcv, pre_out, exp);
                    end
                end
                rcv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (rcv !== 1000 || sent !== 1000 || q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL rand_count: got sent=%0d rcv=%0d pending=%0d expected 1000/1000/0",
                     sent, rcv, q.size());
        end
    endtask

    initial begin
        initModel();
        test_reset();
        test_fips();
        test_sweep();
        test_backpressure();
        test_clear();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
